// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: forwarding select encoding and default widths
package fwd_hazard_ctrl_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF = 16;
  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB = 2'd2;
endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage operands/controls in (master drives), forwarding selects, stall and stall count out (slave drives)
interface fwd_hazard_ctrl_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
  logic fwd_en, freeze, flush;
  logic id_valid, id_two_src, id_is_store, id_wb_en, id_mem_r;
  logic [REG_AW-1:0] id_src1, id_src2, id_st_src, id_dest;
  logic [1:0] val1_sel, val2_sel, ST_val_sel;
  logic hazard_stall;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output fwd_en, freeze, flush, id_valid, id_two_src, id_is_store, id_wb_en, id_mem_r,
    output id_src1, id_src2, id_st_src, id_dest,
    input val1_sel, val2_sel, ST_val_sel, hazard_stall, stall_cnt
  );
  modport slave (
    input fwd_en, freeze, flush, id_valid, id_two_src, id_is_store, id_wb_en, id_mem_r,
    input id_src1, id_src2, id_st_src, id_dest,
    output val1_sel, val2_sel, ST_val_sel, hazard_stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl_match.sv
// fwd_match: one operand against EXE/MEM shadow slots -> select, load-use flag, any-hit flag
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic              e_valid,
  input  logic [REG_AW-1:0] e_dest,
  input  logic              e_wb_en,
  input  logic              e_mem_r,
  input  logic              m_valid,
  input  logic [REG_AW-1:0] m_dest,
  input  logic              m_wb_en,
  output logic [1:0]        sel,
  output logic              load_use,
  output logic              hit
);
  logic match_e, match_m;
  always_comb begin
    match_e = used && src != '0 && e_valid && e_wb_en && src == e_dest;
    match_m = used && src != '0 && m_valid && m_wb_en && src == m_dest;
    sel = (match_e && !e_mem_r) ? SEL_MEM : match_m ? SEL_WB : SEL_REG;
    load_use = match_e && e_mem_r;
    hit = match_e || match_m;
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding select generation and hazard stall control for the execute stage
// ports: clock, rst_n (async active-low), bus (slave: ID operands/controls in, selects/stall/stall_cnt out)
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clock,
  input logic rst_n,
  fwd_hazard_ctrl_if.slave bus
);
  logic e_valid_q, e_valid_d, e_wb_en_q, e_wb_en_d, e_mem_r_q, e_mem_r_d;
  logic [REG_AW-1:0] e_dest_q, e_dest_d, m_dest_q, m_dest_d;
  logic m_valid_q, m_valid_d, m_wb_en_q, m_wb_en_d;
  logic [1:0] sel_q [3];
  logic [1:0] sel_d [3];
  logic [1:0] sel [3];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [REG_AW-1:0] src [3];
  logic [2:0] used, lu, hit;
  logic hazard_stall, bubble;
  assign src = '{bus.id_src1, bus.id_src2, bus.id_st_src};
  assign used = {bus.id_valid && bus.id_is_store, bus.id_valid && bus.id_two_src, bus.id_valid};
  for (genvar i = 0; i < 3; i++) begin : g_m
    fwd_match #(.REG_AW(REG_AW)) u_match (
      .src(src[i]), .used(used[i]),
      .e_valid(e_valid_q), .e_dest(e_dest_q), .e_wb_en(e_wb_en_q), .e_mem_r(e_mem_r_q),
      .m_valid(m_valid_q), .m_dest(m_dest_q), .m_wb_en(m_wb_en_q),
      .sel(sel[i]), .load_use(lu[i]), .hit(hit[i])
    );
  end
  always_comb begin
    // without forwarding any in-flight producer blocks; WB is covered by write-before-read
    hazard_stall = !bus.flush && (bus.fwd_en ? |lu : |hit);
    bubble = hazard_stall || bus.flush || !bus.id_valid;
    m_valid_d = bus.freeze ? m_valid_q : e_valid_q;
    m_dest_d = bus.freeze ? m_dest_q : e_dest_q;
    m_wb_en_d = bus.freeze ? m_wb_en_q : e_wb_en_q;
    e_valid_d = bus.freeze ? e_valid_q : !bubble;
    e_dest_d = bus.freeze ? e_dest_q : bus.id_dest;
    e_wb_en_d = bus.freeze ? e_wb_en_q : bus.id_wb_en;
    e_mem_r_d = bus.freeze ? e_mem_r_q : bus.id_mem_r;
    for (int k = 0; k < 3; k++)
      sel_d[k] = bus.freeze ? sel_q[k] : (bubble || !bus.fwd_en) ? SEL_REG : sel[k];
    stall_cnt_d = (bus.freeze || !hazard_stall || &stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q <= 1'b0;
      e_dest_q <= '0;
      e_wb_en_q <= 1'b0;
      e_mem_r_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_dest_q <= '0;
      m_wb_en_q <= 1'b0;
      sel_q <= '{default: SEL_REG};
      stall_cnt_q <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      e_dest_q <= e_dest_d;
      e_wb_en_q <= e_wb_en_d;
      e_mem_r_q <= e_mem_r_d;
      m_valid_q <= m_valid_d;
      m_dest_q <= m_dest_d;
      m_wb_en_q <= m_wb_en_d;
      sel_q <= sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign bus.val1_sel = sel_q[0];
  assign bus.val2_sel = sel_q[1];
  assign bus.ST_val_sel = sel_q[2];
  assign bus.hazard_stall = hazard_stall;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scenarios for forwarding selects, stalls, freeze, flush and reset
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (.clock(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic two,
                        input logic [4:0] st, input logic is_st, input logic [4:0] d,
                        input logic wb, input logic mr);
    bus.id_valid = v;
    bus.id_src1 = s1;
    bus.id_src2 = s2;
    bus.id_two_src = two;
    bus.id_st_src = st;
    bus.id_is_store = is_st;
    bus.id_dest = d;
    bus.id_wb_en = wb;
    bus.id_mem_r = mr;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.fwd_en = 1'b1;
    bus.freeze = 1'b0;
    bus.flush = 1'b0;
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL reset_val1 got %0d exp 0", bus.val1_sel); end
    checks++; if (bus.val2_sel !== 2'd0) begin errors++; $display("FAIL reset_val2 got %0d exp 0", bus.val2_sel); end
    checks++; if (bus.ST_val_sel !== 2'd0) begin errors++; $display("FAIL reset_st got %0d exp 0", bus.ST_val_sel); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d exp 0", bus.hazard_stall); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.stall_cnt); end
  endtask

  task automatic test_fwd_mem();
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 0);
    step();
    set_id(1, 5'd3, 5'd5, 1, 5'd0, 0, 5'd4, 1, 0);
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL mem_stall got %0d exp 0", bus.hazard_stall); end
    step();
    checks++; if (bus.val1_sel !== 2'd1) begin errors++; $display("FAIL mem_val1 got %0d exp 1", bus.val1_sel); end
    checks++; if (bus.val2_sel !== 2'd0) begin errors++; $display("FAIL mem_val2 got %0d exp 0", bus.val2_sel); end
  endtask

  task automatic test_fwd_wb();
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 0);
    step();
    idle();
    step();
    set_id(1, 5'd6, 5'd0, 0, 5'd3, 1, 5'd0, 0, 0);
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL wb_stall got %0d exp 0", bus.hazard_stall); end
    step();
    checks++; if (bus.ST_val_sel !== 2'd2) begin errors++; $display("FAIL wb_st got %0d exp 2", bus.ST_val_sel); end
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL wb_val1 got %0d exp 0", bus.val1_sel); end
  endtask

  task automatic test_priority_r0();
    do_reset();
    set_id(1, 5'd1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0);
    step();
    set_id(1, 5'd2, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0);
    step();
    set_id(1, 5'd7, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
    step();
    checks++; if (bus.val1_sel !== 2'd1) begin errors++; $display("FAIL prio_val1 got %0d exp 1", bus.val1_sel); end
    set_id(1, 5'd1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    step();
    set_id(1, 5'd0, 5'd0, 1, 5'd0, 1, 5'd10, 1, 0);
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %0d exp 0", bus.hazard_stall); end
    step();
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL r0_val1 got %0d exp 0", bus.val1_sel); end
    checks++; if (bus.val2_sel !== 2'd0) begin errors++; $display("FAIL r0_val2 got %0d exp 0", bus.val2_sel); end
    checks++; if (bus.ST_val_sel !== 2'd0) begin errors++; $display("FAIL r0_st got %0d exp 0", bus.ST_val_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 5'd9, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1);
    step();
    set_id(1, 5'd2, 5'd2, 1, 5'd0, 0, 5'd8, 1, 0);
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall1 got %0d exp 1", bus.hazard_stall); end
    step();
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL lu_bubble_val1 got %0d exp 0", bus.val1_sel); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got %0d exp 0", bus.hazard_stall); end
    step();
    checks++; if (bus.val1_sel !== 2'd2) begin errors++; $display("FAIL lu_val1 got %0d exp 2", bus.val1_sel); end
    checks++; if (bus.val2_sel !== 2'd2) begin errors++; $display("FAIL lu_val2 got %0d exp 2", bus.val2_sel); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", bus.stall_cnt); end
  endtask

  task automatic test_no_fwd();
    do_reset();
    bus.fwd_en = 1'b0;
    set_id(1, 5'd1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 0);
    step();
    set_id(1, 5'd3, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0);
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL nf_stall1 got %0d exp 1", bus.hazard_stall); end
    step();
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL nf_stall2 got %0d exp 1", bus.hazard_stall); end
    step();
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL nf_stall3 got %0d exp 0", bus.hazard_stall); end
    step();
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL nf_val1 got %0d exp 0", bus.val1_sel); end
    checks++; if (bus.val2_sel !== 2'd0) begin errors++; $display("FAIL nf_val2 got %0d exp 0", bus.val2_sel); end
    checks++; if (bus.stall_cnt !== 16'd2) begin errors++; $display("FAIL nf_cnt got %0d exp 2", bus.stall_cnt); end
    bus.fwd_en = 1'b1;
  endtask

  task automatic test_freeze();
    do_reset();
    set_id(1, 5'd1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
    step();
    set_id(1, 5'd3, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1);
    step();
    set_id(1, 5'd2, 5'd2, 1, 5'd0, 0, 5'd8, 1, 0);
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL frz_stall got %0d exp 1", bus.hazard_stall); end
    checks++; if (bus.val1_sel !== 2'd1) begin errors++; $display("FAIL frz_val1 got %0d exp 1", bus.val1_sel); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL frz_cnt got %0d exp 0", bus.stall_cnt); end
    bus.freeze = 1'b0;
    step();
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL frz_cnt_after got %0d exp 1", bus.stall_cnt); end
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL frz_bubble got %0d exp 0", bus.val1_sel); end
    step();
    checks++; if (bus.val1_sel !== 2'd2) begin errors++; $display("FAIL frz_val1_wb got %0d exp 2", bus.val1_sel); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, 5'd9, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1);
    step();
    set_id(1, 5'd2, 5'd2, 1, 5'd0, 0, 5'd5, 1, 0);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %0d exp 0", bus.hazard_stall); end
    step();
    bus.flush = 1'b0;
    set_id(1, 5'd5, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0);
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL fl_cnt got %0d exp 0", bus.stall_cnt); end
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL fl_sel got %0d exp 0", bus.val1_sel); end
    step();
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL fl_bubble got %0d exp 0", bus.val1_sel); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_id(1, 5'd9, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1);
    step();
    set_id(1, 5'd2, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0);
    step();
    step();
    checks++; if (bus.val1_sel !== 2'd2) begin errors++; $display("FAIL ar_pre_val1 got %0d exp 2", bus.val1_sel); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL ar_pre_cnt got %0d exp 1", bus.stall_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.val1_sel !== 2'd0) begin errors++; $display("FAIL ar_val1 got %0d exp 0", bus.val1_sel); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", bus.stall_cnt); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL ar_stall got %0d exp 0", bus.hazard_stall); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_priority_r0();
    test_load_use();
    test_no_fwd();
    test_freeze();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
